// File: rtl/uart_rx_if.sv
// uart_rx_if: serial pin, FIFO read handshake and status lines of the buffered UART receiver.
interface uart_rx_if;
    logic       RX;
    logic       read_data;
    logic [7:0] Data_RX;
    logic       data_valid;
    logic       is_busy;
    logic       frame_error;
    logic       overflow;
    modport slave (input RX, read_data, output Data_RX, data_valid, is_busy, frame_error, overflow);
    modport master (output RX, read_data, input Data_RX, data_valid, is_busy, frame_error, overflow);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with stop-bit check and a 16-entry first-word-fall-through FIFO.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input logic     Clk,
    input logic     Rst,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] H_C = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] N_C = CW'(CLKS_PER_BIT);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, WAIT_HIGH = 3'd4;

    logic          sync1_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_error_q, frame_error_d;
    logic          overflow_q, overflow_d;
    logic [3:0]    head_q, head_d, tail_q, tail_d;
    logic [4:0]    count_q, count_d;
    logic [7:0]    mem_q [16];
    logic [7:0]    mem_d [16];
    logic          good, pop, push, full;

    // cnt holds the cycle number since the falling edge, restarting at 1 after each sample point
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        frame_error_d = 1'b0;
        good = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = CW'(1);
                state_d = rx_s_q ? IDLE : START;
            end
            START: if (cnt_q == H_C) begin
                state_d = rx_s_q ? IDLE : DATA;
                cnt_d = CW'(1);
                bit_d = 3'd0;
            end
            DATA: if (cnt_q == N_C) begin
                cnt_d = CW'(1);
                shift_d = {rx_s_q, shift_q[7:1]};
                bit_d = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == N_C) begin
                state_d = rx_s_q ? IDLE : WAIT_HIGH;
                good = rx_s_q;
                frame_error_d = !rx_s_q;
            end
            WAIT_HIGH: state_d = rx_s_q ? IDLE : WAIT_HIGH;
            default: state_d = IDLE;
        endcase
    end

    // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    always_comb begin
        pop = bus.read_data && (count_q != 5'd0);
        full = (count_q == 5'd16);
        push = good && (!full || pop);
        overflow_d = overflow_q | (good && full && !pop);
        mem_d = mem_q;
        if (push) mem_d[head_q] = shift_q;
        head_d = head_q + {3'b0, push};
        tail_d = tail_q + {3'b0, pop};
        count_d = count_q + {4'b0, push} - {4'b0, pop};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= 1'b1;
            rx_s_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            frame_error_q <= 1'b0;
            overflow_q <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            mem_q <= '{default: '0};
        end else begin
            sync1_q <= bus.RX;
            rx_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            frame_error_q <= frame_error_d;
            overflow_q <= overflow_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            mem_q <= mem_d;
        end
    end

    assign bus.Data_RX = mem_q[tail_q];
    assign bus.data_valid = (count_q != 5'd0);
    assign bus.is_busy = (state_q != IDLE);
    assign bus.frame_error = frame_error_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random 8N1 frames checked against a queue model of the receive FIFO.
module tb_uart_rx;
    localparam int N = 16;
    localparam int S = N / 2 + 9 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    logic [7:0] q[$];
    logic ovf_m = 1'b0;

    uart_rx_if bus ();
    uart_rx #(.CLKS_PER_BIT(N)) dut (.Clk(clk), .Rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) if (bus.frame_error) fe_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fifo(input string tag);
        check({tag, ".valid"}, 32'(bus.data_valid), 32'(q.size() != 0));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(ovf_m));
        if (q.size() != 0) check({tag, ".data"}, 32'(bus.Data_RX), 32'(q[0]));
    endtask

    // a good byte either joins the queue, replaces the popped head, or is lost to overflow
    task automatic model_frame(input logic [7:0] b, input bit popped);
        if (popped) begin
            void'(q.pop_front());
            q.push_back(b);
        end else if (q.size() == 16) ovf_m = 1'b1;
        else q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit timing, input bit pop_at_push);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10 * N; k++) begin
            bus.RX = f[k / N];
            if (pop_at_push) bus.read_data = (k == S + 2);
            tick;
            if (timing && k == S + 1) check("dv_before_rise", 32'(bus.data_valid), 32'd0);
            if (timing && k == S + 2) check("dv_rise", 32'(bus.data_valid), 32'd1);
        end
    endtask

    task automatic pop_one(input string tag);
        bus.read_data = 1'b1;
        tick;
        bus.read_data = 1'b0;
        void'(q.pop_front());
        check_fifo(tag);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, 32'(bus.data_valid), 32'd0);
        check({tag, ".busy"}, 32'(bus.is_busy), 32'd0);
        check({tag, ".ferr"}, 32'(bus.frame_error), 32'd0);
        check({tag, ".ovf"}, 32'(bus.overflow), 32'd0);
        check({tag, ".data"}, 32'(bus.Data_RX), 32'd0);
    endtask

    initial begin
        int fe0;
        logic [7:0] b;
        logic [9:0] f;
        bus.RX = 1'b1;
        bus.read_data = 1'b0;
        repeat (3) tick;
        check_idle_outputs("reset");
        rst = 1'b0;
        tick;

        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        model_frame(8'hA5, 1'b0);
        check("a5_data", 32'(bus.Data_RX), 32'hA5);
        pop_one("a5_pop");

        for (int i = 0; i < 16; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
            model_frame(8'(i), 1'b0);
            check_fifo("fill");
        end
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        model_frame(8'hFF, 1'b0);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check_fifo("ovf_fifo");
        while (q.size() != 0) pop_one("drain_fill");

        fe0 = fe_cnt;
        bus.RX = 1'b0;
        repeat (3) tick;
        bus.RX = 1'b1;
        check("glitch_busy", 32'(bus.is_busy), 32'd1);
        repeat (8) tick;
        check("glitch_idle", 32'(bus.is_busy), 32'd0);
        check("glitch_ferr", 32'(fe_cnt), 32'(fe0));
        check_fifo("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) tick;
        check("ferr_pulses", 32'(fe_cnt), 32'(fe0 + 1));
        check("ferr_busy", 32'(bus.is_busy), 32'd1);
        check_fifo("ferr_nopush");
        bus.RX = 1'b1;
        repeat (4) tick;
        check("ferr_release", 32'(bus.is_busy), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        model_frame(8'h5A, 1'b0);
        check_fifo("after_ferr");
        pop_one("after_ferr_pop");

        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b0);
        model_frame(b, 1'b0);
        check_fifo("pre_rst");
        f = {1'b1, 8'h81, 1'b0};
        for (int k = 0; k < 5 * N; k++) begin
            bus.RX = f[k / N];
            tick;
        end
        rst = 1'b1;
        bus.RX = 1'b1;
        tick;
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        check_idle_outputs("mid_rst");
        repeat (2 * N) tick;
        check_idle_outputs("post_rst");
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        model_frame(8'h42, 1'b0);
        check("rst_next", 32'(bus.Data_RX), 32'h42);
        pop_one("rst_next_pop");

        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0, 1'b0);
            model_frame(b, 1'b0);
        end
        check_fifo("full_again");
        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        model_frame(8'h77, 1'b1);
        check("simul_ovf", 32'(bus.overflow), 32'd0);
        check_fifo("simul");
        for (int i = 0; i < 15; i++) pop_one("simul_drain");
        check("simul_last", 32'(bus.Data_RX), 32'h77);
        pop_one("simul_empty");

        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 1'b0, 1'b0);
            model_frame(b, 1'b0);
            check_fifo("rand_rx");
            if ($urandom_range(0, 1) == 1) pop_one("rand_pop");
            repeat ($urandom_range(0, 5)) tick;
        end
        while (q.size() != 0) pop_one("rand_drain");
        check("final_busy", 32'(bus.is_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
